// File: rtl/seg_scan_if.sv
// -----------------------------------------------------------------------------
// seg_scan_if
// Bundle between a scanned seven-segment source and seg_scan_decoder.
//   digit_in    [3:0]  one-hot active-high digit select (bit 0 = value[15:12])
//   seg_in      [7:0]  active-low segments {a,b,c,d,e,f,g,dp}, dp on bit 0
//   value       [15:0] last valid frame as four BCD nibbles
//   value_valid        one-cycle strobe when value updates
//   frame_err          one-cycle strobe when a frame is discarded
//   dp          [3:0]  decimal points of the last valid frame (bit i = digit i)
//   fsm_dbg            debug view of the frame FSM (0 = IDLE, 1 = COLLECT)
// master: the scanning source / observer.  slave: the decoder.
// The scanned inputs carry no handshake: they are free-running levels.
// value_valid and frame_err are fire-and-forget strobes with no ready; a
// consumer must take value/dp in the cycle value_valid is high or rely on
// value/dp holding until the next value_valid.
// -----------------------------------------------------------------------------
interface seg_scan_if;
  logic [3:0]  digit_in;
  logic [7:0]  seg_in;
  logic [15:0] value;
  logic        value_valid;
  logic        frame_err;
  logic [3:0]  dp;
  logic        fsm_dbg;

  modport master (
    output digit_in, seg_in,
    input  value, value_valid, frame_err, dp, fsm_dbg
  );

  modport slave (
    input  digit_in, seg_in,
    output value, value_valid, frame_err, dp, fsm_dbg
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Samples a 4-digit multiplexed seven-segment bus, waits for each scan slot
// to settle, decodes the segment pattern back to BCD, and assembles four
// slots into a 16-bit BCD word reported with a one-cycle strobe.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (release synchronous to clk)
//   bus    seg_scan_if.slave: digit_in/seg_in in; value, value_valid,
//          frame_err, dp, fsm_dbg out
//
// Parameter:
//   SETTLE_CYCLES (1..255): a slot is captured once its synchronized
//   {digit, seg} has been stable for SETTLE_CYCLES+1 samples.
//
// Build option:
//   SEG_SCAN_DP_CAPTURE_EN defined   -> seg[0] captured per slot onto dp
//                                       (1 = point lit).
//   SEG_SCAN_DP_CAPTURE_EN undefined -> dp tied to 0, seg[0] ignored by the
//                                       change detector.
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

`ifdef SEG_SCAN_DP_CAPTURE_EN
  localparam logic [7:0] SEG_CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] SEG_CMP_MASK = 8'hFE;
`endif

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Returns {valid, nibble} for segment pattern seg[7:1] (active low a..g).
  function automatic logic [4:0] decode7(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001111: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
      default:    r = {1'b0, 4'hF};
    endcase
    return r;
  endfunction

  // Synchronizers and previous-sample register.
  logic [3:0]  dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d, dig_p_q, dig_p_d;
  logic [7:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_p_q, seg_p_d;

  // Settle tracking.
  logic [7:0]  cnt_q, cnt_d;
  logic        fired_q, fired_d;
  logic        changed;
  logic        capture;

  // Frame assembly.
  state_e      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic        inv_q, inv_d;
  logic [15:0] buf_q, buf_d;

  // Outputs.
  logic [15:0] value_q, value_d;
  logic        vv_q, vv_d;
  logic        fe_q, fe_d;
  logic [3:0]  dp_q, dp_d;

`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic [3:0]  dpbuf_q, dpbuf_d;
  logic [3:0]  dpbuf_ins;
`else
  logic        unused_seg_dp;
  assign unused_seg_dp = seg_p_q[0];
`endif

  // Capture decode helpers.
  logic [4:0]  dec;
  logic [3:0]  cap_nib;
  logic        cap_bad;
  logic [1:0]  cap_pos;
  logic        cap_one;
  logic        cap_multi;
  logic [3:0]  pos_bit;
  logic [3:0]  mask_ins;
  logic        inv_ins;
  logic [15:0] buf_ins;

  // ---------------------------------------------------------------------------
  // Front end: synchronizers, change detect, settle counter.
  // The counter saturates at SETTLE; capture fires once when it gets there
  // and fired_q blocks repeats until the input changes again. The captured
  // data comes from the previous-sample register, which holds the value that
  // was stable for the whole count even if the input changes in this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    dig_s1_d = bus.digit_in;
    dig_s2_d = dig_s1_q;
    dig_p_d  = dig_s2_q;
    seg_s1_d = bus.seg_in;
    seg_s2_d = seg_s1_q;
    seg_p_d  = seg_s2_q;

    changed = (dig_s2_q != dig_p_q) ||
              ((seg_s2_q & SEG_CMP_MASK) != (seg_p_q & SEG_CMP_MASK));
    capture = (cnt_q == SETTLE) && !fired_q;

    cnt_d = cnt_q;
    if (changed) begin
      cnt_d = 8'd0;
    end else if (cnt_q != SETTLE) begin
      cnt_d = cnt_q + 8'd1;
    end

    fired_d = changed ? 1'b0 : (fired_q | capture);
  end

  // ---------------------------------------------------------------------------
  // Slot classification and the values a capture would write.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec     = decode7(seg_p_q[7:1]);
    cap_nib = dec[3:0];
    cap_bad = ~dec[4];

    cap_pos   = 2'd0;
    cap_one   = 1'b0;
    cap_multi = 1'b0;
    case (dig_p_q)
      4'b0000: ;
      4'b0001: begin cap_pos = 2'd0; cap_one = 1'b1; end
      4'b0010: begin cap_pos = 2'd1; cap_one = 1'b1; end
      4'b0100: begin cap_pos = 2'd2; cap_one = 1'b1; end
      4'b1000: begin cap_pos = 2'd3; cap_one = 1'b1; end
      default: cap_multi = 1'b1;
    endcase

    pos_bit  = 4'b0001 << cap_pos;
    mask_ins = mask_q | pos_bit;
    inv_ins  = inv_q | cap_bad;

    buf_ins = buf_q;
    case (cap_pos)
      2'd0:    buf_ins[15:12] = cap_nib;
      2'd1:    buf_ins[11:8]  = cap_nib;
      2'd2:    buf_ins[7:4]   = cap_nib;
      default: buf_ins[3:0]   = cap_nib;
    endcase

`ifdef SEG_SCAN_DP_CAPTURE_EN
    dpbuf_ins          = dpbuf_q;
    dpbuf_ins[cap_pos] = ~seg_p_q[0];
`endif
  end

  // ---------------------------------------------------------------------------
  // Frame FSM. A frame always starts at position 0; afterwards positions may
  // arrive in any order. A repeat of position 0 restarts the frame with that
  // capture; a repeat of any other position abandons it.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    inv_d   = inv_q;
    buf_d   = buf_q;
    value_d = value_q;
    dp_d    = dp_q;
    vv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef SEG_SCAN_DP_CAPTURE_EN
    dpbuf_d = dpbuf_q;
`endif

    if (capture && cap_multi) begin
      fe_d    = 1'b1;
      state_d = IDLE;
      mask_d  = 4'b0000;
      inv_d   = 1'b0;
    end else if (capture && cap_one) begin
      case (state_q)
        IDLE: begin
          if (cap_pos == 2'd0) begin
            buf_d   = buf_ins;
            mask_d  = 4'b0001;
            inv_d   = cap_bad;
            state_d = COLLECT;
`ifdef SEG_SCAN_DP_CAPTURE_EN
            dpbuf_d = dpbuf_ins;
`endif
          end
        end
        COLLECT: begin
          if ((mask_q & pos_bit) != 4'b0000) begin
            fe_d = 1'b1;
            if (cap_pos == 2'd0) begin
              buf_d  = buf_ins;
              mask_d = 4'b0001;
              inv_d  = cap_bad;
`ifdef SEG_SCAN_DP_CAPTURE_EN
              dpbuf_d = dpbuf_ins;
`endif
            end else begin
              state_d = IDLE;
              mask_d  = 4'b0000;
              inv_d   = 1'b0;
            end
          end else if (mask_ins == 4'b1111) begin
            state_d = IDLE;
            mask_d  = 4'b0000;
            inv_d   = 1'b0;
            buf_d   = buf_ins;
            if (!inv_ins) begin
              value_d = buf_ins;
              vv_d    = 1'b1;
`ifdef SEG_SCAN_DP_CAPTURE_EN
              dp_d    = dpbuf_ins;
`endif
            end else begin
              fe_d = 1'b1;
            end
          end else begin
            buf_d  = buf_ins;
            mask_d = mask_ins;
            inv_d  = inv_ins;
`ifdef SEG_SCAN_DP_CAPTURE_EN
            dpbuf_d = dpbuf_ins;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_s1_q <= 4'b0000;
      dig_s2_q <= 4'b0000;
      dig_p_q  <= 4'b0000;
      seg_s1_q <= 8'h00;
      seg_s2_q <= 8'h00;
      seg_p_q  <= 8'h00;
      cnt_q    <= 8'd0;
      fired_q  <= 1'b0;
      state_q  <= IDLE;
      mask_q   <= 4'b0000;
      inv_q    <= 1'b0;
      buf_q    <= 16'h0000;
      value_q  <= 16'h0000;
      vv_q     <= 1'b0;
      fe_q     <= 1'b0;
      dp_q     <= 4'b0000;
`ifdef SEG_SCAN_DP_CAPTURE_EN
      dpbuf_q  <= 4'b0000;
`endif
    end else begin
      dig_s1_q <= dig_s1_d;
      dig_s2_q <= dig_s2_d;
      dig_p_q  <= dig_p_d;
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      seg_p_q  <= seg_p_d;
      cnt_q    <= cnt_d;
      fired_q  <= fired_d;
      state_q  <= state_d;
      mask_q   <= mask_d;
      inv_q    <= inv_d;
      buf_q    <= buf_d;
      value_q  <= value_d;
      vv_q     <= vv_d;
      fe_q     <= fe_d;
      dp_q     <= dp_d;
`ifdef SEG_SCAN_DP_CAPTURE_EN
      dpbuf_q  <= dpbuf_d;
`endif
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = vv_q;
  assign bus.frame_err   = fe_q;
  assign bus.dp          = dp_q;
  assign bus.fsm_dbg     = (state_q == COLLECT);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Drives scanned frames into seg_scan_decoder (SETTLE_CYCLES = 4) and checks
// every value_valid / frame_err strobe against an expected-result queue that
// is filled when the completing (or offending) slot is driven.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

`ifdef SEG_SCAN_DP_CAPTURE_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if bus();

  seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- scoreboard
  // Entry layout: {frame_err, dp, value}
  logic [20:0] exp_q[$];
  logic [20:0] mon_e;
  logic [15:0] last_val;
  logic [3:0]  last_dp;
  logic [15:0] prev_val;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          vv_first;
  int          vv_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic lit);
    logic [6:0] c;
    case (nib)
      4'd0: c = 7'b0000001;
      4'd1: c = 7'b1001111;
      4'd2: c = 7'b0010010;
      4'd3: c = 7'b0000110;
      4'd4: c = 7'b1001100;
      4'd5: c = 7'b0100100;
      4'd6: c = 7'b0100000;
      4'd7: c = 7'b0001111;
      4'd8: c = 7'b0000000;
      4'd9: c = 7'b0000100;
      default: c = 7'b1111111;
    endcase
    return {c, ~lit};
  endfunction

  task automatic slot(input logic [3:0] dig, input logic [7:0] seg, input int cyc);
    bus.digit_in = dig;
    bus.seg_in   = seg;
    vv_first = -1;
    vv_cnt   = 0;
    for (int i = 1; i <= cyc; i++) begin
      @(negedge clk);
      if (bus.value_valid) begin
        vv_cnt++;
        if (vv_first < 0) vv_first = i;
      end
    end
  endtask

  task automatic push_ok(input logic [15:0] v, input logic [3:0] d);
    logic [3:0] de;
    de = DP_EN ? d : 4'b0000;
    exp_q.push_back({1'b0, de, v});
    last_val = v;
    last_dp  = de;
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, last_dp, last_val});
  endtask

  task automatic frame(input logic [15:0] v, input logic [3:0] dpm, input bit shuffle);
    int ord[4];
    int j;
    int t;
    int p;
    for (int k = 0; k < 4; k++) ord[k] = k;
    if (shuffle) begin
      for (int k = 3; k >= 2; k--) begin
        j = $urandom_range(1, k);
        t = ord[k]; ord[k] = ord[j]; ord[j] = t;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = ord[k];
      if (k == 3) push_ok(v, dpm);
      slot(4'b0001 << p, seg_of(v[15-4*p -: 4], dpm[p]), 16);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_val <= 16'h0000;
    end else begin
      if (bus.value_valid && bus.frame_err)
        check("strobe_excl", {31'd0, bus.value_valid & bus.frame_err}, 32'd0);
      if (bus.value_valid || bus.frame_err) begin
        check("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("frame_result", {11'd0, bus.frame_err, bus.dp, bus.value}, {11'd0, mon_e});
        end
      end
      if (!bus.value_valid && (bus.value !== prev_val))
        check("value_stable", {16'd0, bus.value}, {16'd0, prev_val});
      prev_val <= bus.value;
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic [15:0] rv;
  logic [3:0]  rdp;

  initial begin
    bus.digit_in = 4'b0000;
    bus.seg_in   = 8'hFF;
    last_val     = 16'h0000;
    last_dp      = 4'b0000;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_value", {16'd0, bus.value}, 32'h0);
    check("rst_vv",    {31'd0, bus.value_valid}, 32'h0);
    check("rst_fe",    {31'd0, bus.frame_err}, 32'h0);
    check("rst_dp",    {28'd0, bus.dp}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Normal frame 1234, latency and single-cycle strobe.
    slot(4'b0001, 8'b10011111, 16);
    slot(4'b0010, 8'b00100101, 16);
    slot(4'b0100, 8'b00001101, 16);
    push_ok(16'h1234, 4'b0000);
    slot(4'b1000, 8'b10011001, 16);
    check("latency", vv_first, 8);
    check("vv_once", vv_cnt, 1);
    check("value_1234", {16'd0, bus.value}, 32'h1234);

    // Glitch: short dwell slot must not be captured.
    slot(4'b0001, 8'b10011111, 16);
    slot(4'b0010, 8'b00100101, 16);
    slot(4'b0100, 8'b10011001, 2);
    slot(4'b0100, 8'b00001101, 16);
    push_ok(16'h1234, 4'b0000);
    slot(4'b1000, 8'b10011001, 16);
    check("glitch_vv", vv_cnt, 1);

    // Blank slot: frame discarded, value held.
    slot(4'b0001, 8'b10011111, 16);
    slot(4'b0010, 8'b00100101, 16);
    slot(4'b0100, 8'b11111111, 16);
    push_err();
    slot(4'b1000, 8'b10011001, 16);
    check("blank_vv", vv_cnt, 0);
    check("blank_value", {16'd0, bus.value}, 32'h1234);

    // Repeated position 0 restarts the frame.
    slot(4'b0001, seg_of(4'd1, 1'b0), 16);
    slot(4'b0010, seg_of(4'd2, 1'b0), 16);
    push_err();
    slot(4'b0001, seg_of(4'd5, 1'b0), 16);
    slot(4'b0010, seg_of(4'd6, 1'b0), 16);
    slot(4'b0100, seg_of(4'd7, 1'b0), 16);
    push_ok(16'h5678, 4'b0000);
    slot(4'b1000, seg_of(4'd8, 1'b0), 16);
    check("repeat_value", {16'd0, bus.value}, 32'h5678);

    // Multi-hot digit aborts; remaining slots are ignored in IDLE.
    slot(4'b0001, seg_of(4'd9, 1'b0), 16);
    slot(4'b0010, seg_of(4'd9, 1'b0), 16);
    push_err();
    slot(4'b0011, seg_of(4'd9, 1'b0), 16);
    slot(4'b0100, seg_of(4'd9, 1'b0), 16);
    slot(4'b1000, seg_of(4'd9, 1'b0), 16);
    check("multihot_value", {16'd0, bus.value}, 32'h5678);

    // Decimal point on slot 0010 only.
    frame(16'h1234, 4'b0010, 1'b0);
    check("dp_frame", {28'd0, bus.dp}, DP_EN ? 32'h2 : 32'h0);
    check("dp_value", {16'd0, bus.value}, 32'h1234);

    // Random frames, random order after position 0, random points.
    for (int r = 0; r < 5; r++) begin
      rv  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rdp = 4'($urandom_range(0, 15));
      frame(rv, rdp, 1'b1);
      check("rand_value", {16'd0, bus.value}, {16'd0, rv});
      check("rand_dp", {28'd0, bus.dp}, DP_EN ? {28'd0, rdp} : 32'h0);
    end

    // Force a known nonzero value, then reset mid-frame.
    frame(16'h9087, 4'b0001, 1'b0);
    slot(4'b0001, seg_of(4'd3, 1'b0), 16);
    bus.digit_in = 4'b0010;
    bus.seg_in   = seg_of(4'd4, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_value", {16'd0, bus.value}, 32'h0);
    check("midrst_vv",    {31'd0, bus.value_valid}, 32'h0);
    check("midrst_fe",    {31'd0, bus.frame_err}, 32'h0);
    check("midrst_dp",    {28'd0, bus.dp}, 32'h0);
    last_val = 16'h0000;
    last_dp  = 4'b0000;
    repeat (4) @(negedge clk);
    check("rst_hold_value", {16'd0, bus.value}, 32'h0);
    check("rst_hold_dp",    {28'd0, bus.dp}, 32'h0);
    rst_n = 1'b1;
    slot(4'b0000, 8'hFF, 12);
    check("post_rst_value", {16'd0, bus.value}, 32'h0);

    // Normal operation after reset.
    frame(16'h1234, 4'b0000, 1'b0);
    check("post_rst_frame", {16'd0, bus.value}, 32'h1234);

    slot(4'b0000, 8'hFF, 20);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
